// File: rtl/nco_sweep_ctrl.sv
// Frequency-sweep sequencer driving phi_inc/clken of the 32-bit NCO; settles, dwells, steps.
// Optional macro NCO_SWEEP_PINGPONG_EN: sweep back down to phi_start after the last point.
module nco_sweep_ctrl #(
  parameter int unsigned PHI_W = 32,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned LAT   = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_valid_i,
  input  logic [PHI_W-1:0] cfg_phi_start_i,
  input  logic [PHI_W-1:0] cfg_phi_step_i,
  input  logic [CNT_W-1:0] cfg_nsteps_i,
  input  logic [CNT_W-1:0] cfg_dwell_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             nco_valid_i,
  output logic [PHI_W-1:0] phi_inc_o,
  output logic             nco_clken_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             sample_valid_o,
  output logic [CNT_W-1:0] point_idx_o,
  output logic             point_start_o
);

  typedef enum logic [1:0] {IDLE, SETTLE, DWELL} state_t;

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LAT - 1);

  state_t           state;
  logic [PHI_W-1:0] phi_start_q;
  logic [PHI_W-1:0] phi_step_q;
  logic [CNT_W-1:0] nsteps_q;
  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] cnt_q;

  logic [CNT_W-1:0] n_last;
  logic [CNT_W-1:0] d_last;
  logic [PHI_W-1:0] phi_first;
  logic [PHI_W-1:0] phi_nxt;
  logic             more;

`ifdef NCO_SWEEP_PINGPONG_EN
  logic             rev_q;
  logic             rev_nxt;
  logic [CNT_W-1:0] leg_q;
  logic [CNT_W-1:0] leg_nxt;
`endif

  // Zero counts behave as one; a same-edge config load feeds the first phi directly.
  always_comb begin
    n_last    = (nsteps_q == '0) ? '0 : nsteps_q - CNT_W'(1);
    d_last    = (dwell_q  == '0) ? '0 : dwell_q  - CNT_W'(1);
    phi_first = cfg_valid_i ? cfg_phi_start_i : phi_start_q;
  end

  // Decide whether another point follows the current one and what its phi is.
  always_comb begin
    more    = 1'b0;
    phi_nxt = phi_inc_o;
`ifdef NCO_SWEEP_PINGPONG_EN
    rev_nxt = rev_q;
    leg_nxt = leg_q;
    if (!rev_q) begin
      if (leg_q < n_last) begin
        more    = 1'b1;
        phi_nxt = phi_inc_o + phi_step_q;
        leg_nxt = leg_q + CNT_W'(1);
      end else if (n_last != '0) begin
        more    = 1'b1;
        rev_nxt = 1'b1;
        phi_nxt = phi_inc_o - phi_step_q;
        leg_nxt = leg_q - CNT_W'(1);
      end
    end else if (leg_q != '0) begin
      more    = 1'b1;
      phi_nxt = phi_inc_o - phi_step_q;
      leg_nxt = leg_q - CNT_W'(1);
    end
`else
    if (point_idx_o < n_last) begin
      more    = 1'b1;
      phi_nxt = phi_inc_o + phi_step_q;
    end
`endif
  end

  assign sample_valid_o = (state == DWELL) && nco_valid_i;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      phi_start_q   <= '0;
      phi_step_q    <= '0;
      nsteps_q      <= '0;
      dwell_q       <= '0;
      cnt_q         <= '0;
      phi_inc_o     <= '0;
      nco_clken_o   <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      point_idx_o   <= '0;
      point_start_o <= 1'b0;
`ifdef NCO_SWEEP_PINGPONG_EN
      rev_q         <= 1'b0;
      leg_q         <= '0;
`endif
    end else begin
      point_start_o <= 1'b0;
      done_o        <= 1'b0;
      case (state)
        IDLE: begin
          if (cfg_valid_i) begin
            phi_start_q <= cfg_phi_start_i;
            phi_step_q  <= cfg_phi_step_i;
            nsteps_q    <= cfg_nsteps_i;
            dwell_q     <= cfg_dwell_i;
          end
          if (start_i) begin
            state         <= SETTLE;
            phi_inc_o     <= phi_first;
            point_idx_o   <= '0;
            point_start_o <= 1'b1;
            nco_clken_o   <= 1'b1;
            busy_o        <= 1'b1;
            cnt_q         <= '0;
`ifdef NCO_SWEEP_PINGPONG_EN
            rev_q         <= 1'b0;
            leg_q         <= '0;
`endif
          end
        end
        SETTLE, DWELL: begin
          if (abort_i) begin
            state       <= IDLE;
            nco_clken_o <= 1'b0;
            busy_o      <= 1'b0;
          end else if (state == SETTLE) begin
            if (cnt_q == SETTLE_LAST) begin
              state <= DWELL;
              cnt_q <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end else if (nco_valid_i) begin
            if (cnt_q == d_last) begin
              cnt_q <= '0;
              if (more) begin
                state         <= SETTLE;
                phi_inc_o     <= phi_nxt;
                point_idx_o   <= point_idx_o + CNT_W'(1);
                point_start_o <= 1'b1;
`ifdef NCO_SWEEP_PINGPONG_EN
                rev_q         <= rev_nxt;
                leg_q         <= leg_nxt;
`endif
              end else begin
                state       <= IDLE;
                done_o      <= 1'b1;
                nco_clken_o <= 1'b0;
                busy_o      <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/nco_sweep_ctrl.md
Name: nco_sweep_ctrl

Overview:
Sequencer that drives the phase-increment and clock-enable inputs of the 32-bit NCO (phi_inc_i, clken) to step through a programmed list of frequencies.
- Holds each frequency for a fixed settle time covering the NCO pipeline latency.
- Then dwells for a programmed number of valid NCO output samples before stepping on.
- Flags which NCO samples belong to a settled frequency point, so the downstream modulator and capture logic can use them directly.

Parameters:
PHI_W, 32, phase-increment width; matches the NCO phi_inc_i width.
CNT_W, 16, width of the point-count, dwell and index counters.
LAT, 8, settle cycles after each phi change (NCO pipeline latency); must be 1..2^CNT_W-1.

Ports:
clk  in  1  system clock; all logic on rising edge.
reset_n  in  1  asynchronous active-low reset.
cfg_valid_i  in  1  config load strobe; honoured only in IDLE.
cfg_phi_start_i  in  PHI_W  first phase increment.
cfg_phi_step_i  in  PHI_W  per-point increment delta, two's complement.
cfg_nsteps_i  in  CNT_W  number of frequency points; 0 is treated as 1.
cfg_dwell_i  in  CNT_W  valid samples per point; 0 is treated as 1.
start_i  in  1  start sweep; honoured only in IDLE.
abort_i  in  1  abort sweep.
nco_valid_i  in  1  NCO out_valid.
phi_inc_o  out  PHI_W  to NCO phi_inc_i.
nco_clken_o  out  1  to NCO clken.
busy_o  out  1  sweep in progress.
done_o  out  1  one-cycle pulse on normal completion.
sample_valid_o  out  1  current NCO sample belongs to a settled point.
point_idx_o  out  CNT_W  index of the current point.
point_start_o  out  1  one-cycle pulse when a new phi is applied.

Behaviour:
- Reset values: all outputs 0; config registers 0; state IDLE.
- FSM states: IDLE, SETTLE, DWELL.
- IDLE:
  - cfg_valid_i loads all four cfg registers.
  - start_i moves to SETTLE, using the config registered that same edge if cfg_valid_i is also high.
  - cfg_valid_i and start_i are ignored outside IDLE.
- On entering SETTLE from IDLE (next cycle):
  - phi_inc_o = phi_start, point_idx_o = 0, point_start_o = 1.
  - nco_clken_o = 1 and busy_o = 1 for all cycles in SETTLE and DWELL; both are 0 in IDLE.
- SETTLE lasts exactly LAT cycles, regardless of nco_valid_i, then goes to DWELL.
- DWELL:
  - sample_valid_o = nco_valid_i (combinational from registered state); it is 0 in all other states.
  - The dwell counter increments only on nco_valid_i.
  - On the D-th valid sample (D = max(dwell,1)):
    - If point_idx_o < N-1 (N = max(nsteps,1)): at the next edge phi_inc_o += step (mod 2^PHI_W, wraps silently), point_idx_o++, point_start_o = 1, state SETTLE.
    - Otherwise: state IDLE, done_o = 1 for one cycle, busy_o = 0.
- phi_inc_o holds its last value in IDLE.
- Timing: with nco_valid_i tied high and start at cycle t, point k is applied at t+1+k*(LAT+D) and done_o asserts at cycle t+1+N*(LAT+D).
- abort_i has top priority in any non-IDLE state: next cycle IDLE, clken/busy/sample_valid 0, no done_o, phi_inc_o held. abort_i in IDLE has no effect.
- reset_n low mid-sweep: immediate return to reset values.

Optional Feature:
NCO_SWEEP_PINGPONG_EN
- Defined:
  - After reaching point N-1, the sweep reverses: phi -= step, point_idx_o continues incrementing, and the sweep stops after returning to phi_start.
  - Total 2N-1 points; the endpoint is not repeated. N=1 gives a single point.
  - done_o asserts at t+1+(2N-1)*(LAT+D).
- Undefined: single-direction sweep of N points only; no reverse logic is synthesised.

Test Plan:
1. Reset: assert reset_n=0 mid-DWELL -> all outputs 0 immediately; after release, state IDLE and start_i is required to run again.
2. Basic sweep: LAT=8, start=0x20000000, step=0x01000000, N=3, D=4, nco_valid_i=1, start at cycle 0 -> phi 0x20000000/0x21000000/0x22000000 applied at cycles 1/13/25; 4 sample_valid_o per point; done_o exactly at cycle 37.
3. Wrap and negative step: start=0xFF000000, step=0x01000000, N=2 -> second phi 0x00000000. Then start=0x00000000, step=0xFF000000 -> second phi 0xFF000000.
4. Valid gaps: nco_valid_i alternating 1/0, D=4 -> exactly 4 sample_valid_o per point; DWELL lasts 8 cycles. N=0 or D=0 behaves as 1.
5. Abort and ignore: start_i/cfg_valid_i with new values while busy -> ignored, sweep unchanged. abort_i during SETTLE of point 1 -> IDLE next cycle, no done_o, phi_inc_o held at point-1 value.
6. PINGPONG_EN, same config as test 2 -> phi sequence 0x20,0x21,0x22,0x21,0x20 (×2^24); point_idx_o 0..4; done_o at cycle 61.
